buyruk_bellegi_yukleyici: RTL

Program loader that writes instruction memory from a byte stream (UART/Wishbone byte bridge) through the instruction-memory port (addr/en/we/din), so the core can later fetch from SRAM port 1.
Assembles 4 little-endian bytes per word and issues one full-word write per word.
Holds the core in stall while loading and reports completion plus a running checksum.

---
 rtl/buyruk_bellegi_yukleyici_pkg.sv | 15 +
 rtl/buyruk_bellegi_yukleyici_toplayici.sv | 32 +++
 rtl/buyruk_bellegi_yukleyici.sv | 105 ++++++++++
 3 files changed

// File: rtl/buyruk_bellegi_yukleyici_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// default instruction-memory address width and the full-word write mask.
package buyruk_bellegi_yukleyici_pkg;

   localparam int         BB_ADRES_BIT       = 9;
   localparam logic [3:0] TAM_KELIME_MASKESI = 4'hF;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      TOPLA = 2'd1,
      YAZ   = 2'd2,
      BITTI = 2'd3
   } durum_t;

endpackage

// File: rtl/buyruk_bellegi_yukleyici_toplayici.sv
// Byte-to-word assembler: a lane index plus a 32-bit little-endian word
// register; dolu_o flags the handshake that completes the word.
module bayt_kelime_toplayici (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        temizle_i,
   input  logic        yukle_i,
   input  logic [7:0]  bayt_i,
   output logic [31:0] kelime_o,
   output logic        dolu_o
);

   logic [1:0]  sira_q;
   logic [31:0] kelime_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sira_q   <= 2'd0;
         kelime_q <= 32'd0;
      end else if (temizle_i) begin
         sira_q <= 2'd0;
      end else if (yukle_i) begin
         // lane 0 is bits 7:0; the index wraps to 0 after the 4th byte
         kelime_q[{sira_q, 3'b000} +: 8] <= bayt_i;
         sira_q                          <= sira_q + 2'd1;
      end
   end

   assign kelime_o = kelime_q;
   assign dolu_o   = yukle_i && (sira_q == 2'd3);

endmodule

// File: rtl/buyruk_bellegi_yukleyici.sv
// Loads instruction memory from a byte stream, one full-word write per four
// bytes, stalling the core meanwhile and keeping a running word checksum.
// Byte handshake: a byte moves on a clock edge where bayt_gecerli_i and
// bayt_hazir_o are both 1; ready comes from registered state only.
module buyruk_bellegi_yukleyici
   import buyruk_bellegi_yukleyici_pkg::*;
#(
   parameter int ADRES_BIT = BB_ADRES_BIT,
   parameter int SAYAC_BIT = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 baslat_i,
   input  logic [ADRES_BIT-1:0] baslangic_adresi_i,
   input  logic [SAYAC_BIT-1:0] kelime_sayisi_i,
   input  logic                 iptal_i,
   input  logic                 bayt_gecerli_i,
   input  logic [7:0]           bayt_i,
   output logic                 bayt_hazir_o,
   output logic [ADRES_BIT-1:0] bb_adres_o,
   output logic [31:0]          bb_veri_o,
   output logic                 bb_etkin_o,
   output logic [3:0]           bb_yaz_o,
   output logic                 cekirdek_durdur_o,
   output logic                 tamam_o,
   output logic [31:0]          saglama_o,
   output durum_t               durum_o
);

   durum_t               durum_q, durum_n;
   logic [ADRES_BIT-1:0] adres_q, bb_adres_q;
   logic [SAYAC_BIT-1:0] kalan_q;
   logic [31:0]          saglama_q, bb_veri_q, kelime;
   logic                 durdur_q, tamam_q;
   logic                 basla, iptal_etkin, el_sikisma, dolu, yaz_aktif;

   assign basla       = (durum_q == BOSTA) && baslat_i && !iptal_i;
   assign iptal_etkin = (durum_q != BOSTA) && iptal_i;
   assign el_sikisma  = bayt_hazir_o && bayt_gecerli_i;
   assign yaz_aktif   = (durum_q == YAZ);

   bayt_kelime_toplayici u_toplayici (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .temizle_i(basla || iptal_etkin),
      .yukle_i  (el_sikisma),
      .bayt_i   (bayt_i),
      .kelime_o (kelime),
      .dolu_o   (dolu)
   );

   always_comb begin
      durum_n = durum_q;
      unique case (durum_q)
         BOSTA: if (basla) durum_n = (kelime_sayisi_i == '0) ? BITTI : TOPLA;
         TOPLA: if (dolu) durum_n = YAZ;
         YAZ:   durum_n = (kalan_q == SAYAC_BIT'(1)) ? BITTI : TOPLA;
         BITTI: durum_n = BOSTA;
         default: durum_n = BOSTA;
      endcase
      if (iptal_etkin) durum_n = BOSTA;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         durum_q    <= BOSTA;
         adres_q    <= '0;
         kalan_q    <= '0;
         saglama_q  <= 32'd0;
         bb_adres_q <= '0;
         bb_veri_q  <= 32'd0;
         durdur_q   <= 1'b0;
         tamam_q    <= 1'b0;
      end else begin
         durum_q <= durum_n;
         // stall rises with the start edge and lasts through the cycle after BITTI
         durdur_q <= (durum_n != BOSTA) || (durum_q == BITTI);
         tamam_q  <= (durum_q == BITTI);
         if (basla) begin
            adres_q   <= baslangic_adresi_i;
            kalan_q   <= kelime_sayisi_i;
            saglama_q <= 32'd0;
         end
         // a write cycle always completes, even alongside an abort
         if (yaz_aktif) begin
            adres_q    <= adres_q + 1'b1;
            kalan_q    <= kalan_q - 1'b1;
            saglama_q  <= saglama_q + kelime;
            bb_adres_q <= adres_q;
            bb_veri_q  <= kelime;
         end
      end
   end

   assign bayt_hazir_o      = (durum_q == TOPLA);
   assign bb_etkin_o        = yaz_aktif;
   assign bb_yaz_o          = yaz_aktif ? TAM_KELIME_MASKESI : 4'h0;
   assign bb_adres_o        = yaz_aktif ? adres_q : bb_adres_q;
   assign bb_veri_o         = yaz_aktif ? kelime : bb_veri_q;
   assign cekirdek_durdur_o = durdur_q;
   assign tamam_o           = tamam_q;
   assign saglama_o         = saglama_q;
   assign durum_o           = durum_q;

endmodule
